decimal_entry: RTL and testbench
================================

Name: decimal_entry

Overview:
- Decimal-to-binary front end; the input-side counterpart of the binary-to-7-segment decimal display path.
- Collects decimal digits one at a time from debounced keypad or switch strobes into a BCD buffer. The buffer is exposed so it can be echoed on the HEX displays.
- On enter, converts the buffer to binary with a multi-cycle multiply-by-10-and-add sequence and delivers the result with a one-cycle valid pulse to the ALU operand registers.

Parameters:
- DIGITS, 4, number of BCD digits held (buffer width 4*DIGITS).
- OUT_W, 16, binary result width; must satisfy 2^OUT_W > 10^DIGITS-1.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- digit_valid  input  1  single-cycle strobe: digit is presented.
- digit  input  4  BCD digit value; legal 0..9.
- backspace  input  1  single-cycle strobe: drop least-significant digit.
- clear  input  1  single-cycle strobe: empty buffer.
- enter  input  1  single-cycle strobe: start conversion.
- bcd  output  4*DIGITS  current buffer, right-aligned, digit 0 = ones.
- count  output  3  number of digits currently held (0..DIGITS).
- busy  output  1  high during CONV and DONE states.
- value  output  OUT_W  last converted binary result; holds until next conversion.
- value_valid  output  1  one-cycle pulse when value updates.
- error  output  1  one-cycle pulse on a rejected digit.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state=IDLE, bcd=0, count=0, busy=0, value=0, value_valid=0, error=0, accumulator=0. Reset wins over every other input in every state, including mid-conversion.
- States:
  - IDLE (collecting) -> CONV on enter.
  - CONV lasts exactly DIGITS cycles -> DONE.
  - DONE lasts 1 cycle -> IDLE.
- IDLE input priority, highest first: clear > enter > backspace > digit_valid. Only the highest active input acts in a given cycle.
- clear: bcd=0, count=0.
- digit_valid with digit<=9 and count<DIGITS: bcd = {bcd[4*DIGITS-5:0], digit}, count+1. Registered next cycle.
- digit_valid with digit>9, or with count==DIGITS: bcd and count unchanged; error=1 for the next cycle only.
- backspace with count>0: bcd = bcd>>4, count-1. With count==0: no-op, no error.
- enter (any count, including 0): acc=0, digit index = DIGITS-1, busy=1 next cycle.
- CONV, each cycle: acc = (acc<<3) + (acc<<1) + bcd[index], then index-1.
  - Leading zero digits contribute nothing, so the result is independent of count.
  - acc is OUT_W bits. No overflow is possible given the OUT_W constraint.
- DONE: value=acc and value_valid=1, both visible in the same cycle. bcd and count are retained so the display keeps the entered number.
- Latency: enter sampled at edge T -> value_valid high in the cycle after edge T+DIGITS+1 (5 edges for DIGITS=4).
- While busy: digit_valid, backspace, clear and enter are ignored and dropped, not queued. error stays 0.
- value_valid and error are never high for more than one consecutive cycle unless re-triggered.

Decomposition:
- Shared package:
  - state enum {IDLE, CONV, DONE}.
  - DIGIT_W=4.
  - BCD_MAX=4'd9.
  - localparam helper for buffer width (4*DIGITS).
- One natural sub-module: mul10_add.
  - Combinational acc*10+d via shift-add.
  - Parameter OUT_W.
  - Reusable by other decimal datapaths.

Test Plan:
- Digits 2,0,4,7 strobed, then enter -> bcd=16'h2047, count=4; value=16'd2047 (16'h07FF) with value_valid pulse exactly 5 edges after enter; busy high for 5 cycles.
- Digits 1,2,3, then backspace -> bcd=16'h0012, count=2. Enter -> value=12. Backspace x3 from count 2 -> count=0, no error.
- Digit 4'hA at count=1 (bcd=0x0005) -> error pulse 1 cycle, bcd=0x0005 unchanged. Digits 1,2,3,4 then 9 -> error pulse, bcd=0x1234, count=4.
- 9,9,9,9 then enter -> value=16'h270F. Enter with count=0 -> value=0 with value_valid pulse.
- clear and digit_valid (digit=7) in the same cycle -> bcd=0, count=0. Digit strobe and clear during busy -> ignored; value still correct.
- rst_n=0 for one edge during CONV -> next cycle busy=0, value=0, bcd=0, count=0; no value_valid pulse afterwards.

Source files
------------

// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the decimal keypad entry path.
// Holds the FSM state encoding and the BCD digit geometry used by the top and its datapath helper.
package decimal_entry_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  function automatic int bcd_width(input int digits);
    return DIGIT_W * digits;
  endfunction

endpackage

// File: rtl/decimal_entry_mul10_add.sv
// Combinational acc*10 + d built from two shifts and adds.
// Reusable step for any decimal-to-binary datapath.
module mul10_add
  import decimal_entry_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic [OUT_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] d,
  output logic [OUT_W-1:0]   res
);

  assign res = (acc << 3) + (acc << 1) + OUT_W'(d);

endmodule

// File: rtl/decimal_entry.sv
// Keypad digit collector with BCD buffer and a multi-cycle BCD-to-binary converter.
// Digits enter on the right; enter walks the buffer most-significant digit first.
module decimal_entry
  import decimal_entry_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   digit_valid,
  input  logic [DIGIT_W-1:0]     digit,
  input  logic                   backspace,
  input  logic                   clear,
  input  logic                   enter,
  output logic [4*DIGITS-1:0]    bcd,
  output logic [2:0]             count,
  output logic                   busy,
  output logic [OUT_W-1:0]       value,
  output logic                   value_valid,
  output logic                   error
);

  localparam int BCD_W = bcd_width(DIGITS);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [2:0] COUNT_MAX = 3'(DIGITS);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [2:0]         count_q, count_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   value_q, value_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               value_valid_q, value_valid_d;
  logic               error_q, error_d;
  logic [DIGIT_W-1:0] cur_digit;
  logic [OUT_W-1:0]   mac_res;

  assign cur_digit = bcd_q[idx_q*DIGIT_W +: DIGIT_W];

  mul10_add #(.OUT_W(OUT_W)) u_mul10_add (
    .acc (acc_q),
    .d   (cur_digit),
    .res (mac_res)
  );

  always_comb begin
    state_d       = state_q;
    bcd_d         = bcd_q;
    count_d       = count_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    error_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // Only the highest-priority strobe acts in a cycle.
        if (clear) begin
          bcd_d   = '0;
          count_d = '0;
        end else if (enter) begin
          acc_d   = '0;
          idx_d   = IDX_W'(DIGITS - 1);
          state_d = CONV;
        end else if (backspace) begin
          if (count_q != 3'd0) begin
            bcd_d   = bcd_q >> DIGIT_W;
            count_d = count_q - 3'd1;
          end
        end else if (digit_valid) begin
          if (digit <= BCD_MAX && count_q < COUNT_MAX) begin
            bcd_d   = (bcd_q << DIGIT_W) | BCD_W'(digit);
            count_d = count_q + 3'd1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      CONV: begin
        acc_d = mac_res;
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) state_d = DONE;
      end
      DONE: begin
        value_d       = acc_q;
        value_valid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bcd_q         <= '0;
      count_q       <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bcd_q         <= bcd_d;
      count_q       <= count_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      error_q       <= error_d;
    end
  end

  assign bcd         = bcd_q;
  assign count       = count_q;
  assign busy        = (state_q != IDLE);
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign error       = error_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Bench for decimal_entry: directed scenarios plus randomized keypad traffic
// checked against a digit-list model of the entry buffer.
module tb_decimal_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        backspace;
  logic        clear;
  logic        enter;
  logic [15:0] bcd;
  logic [2:0]  count;
  logic        busy;
  logic [15:0] value;
  logic        value_valid;
  logic        error;

  int checks = 0;
  int failures = 0;

  // Reference model: the entered digits, most significant first.
  int          digs[$];
  logic        exp_err;
  logic [15:0] exp_value;

  always #5 clk = ~clk;

  decimal_entry #(.DIGITS(4), .OUT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_valid (digit_valid),
    .digit       (digit),
    .backspace   (backspace),
    .clear       (clear),
    .enter       (enter),
    .bcd         (bcd),
    .count       (count),
    .busy        (busy),
    .value       (value),
    .value_valid (value_valid),
    .error       (error)
  );

  function automatic logic [15:0] model_bcd();
    logic [15:0] r = 16'h0;
    foreach (digs[i]) r = (r << 4) | 16'(digs[i]);
    return r;
  endfunction

  function automatic logic [15:0] model_number();
    int n = 0;
    foreach (digs[i]) n = n * 10 + digs[i];
    return 16'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; enter = 1'b0; backspace = 1'b0; digit_valid = 1'b0; digit = 4'd0;
  endtask

  // One IDLE cycle with the given strobes (enter must be low or overridden by clear).
  task automatic step(input logic c, input logic b, input logic dv, input logic [3:0] d);
    clear = c; enter = 1'b0; backspace = b; digit_valid = dv; digit = d;
    tick();
    idle_inputs();
    exp_err = 1'b0;
    if (c) digs.delete();
    else if (b) begin
      if (digs.size() > 0) void'(digs.pop_back());
    end else if (dv) begin
      if (d <= 4'd9 && digs.size() < 4) digs.push_back(int'(d));
      else exp_err = 1'b1;
    end
  endtask

  // Strobe enter (plus optional lower-priority strobes) and watch a bounded window.
  task automatic run_enter(input logic b, input logic dv, input logic [3:0] d, input bit noise,
                           output int busy_n, output int lat, output logic [15:0] got,
                           output int vv_n, output int err_n);
    clear = 1'b0; enter = 1'b1; backspace = b; digit_valid = dv; digit = d;
    tick();
    idle_inputs();
    busy_n = 0; lat = -1; got = 16'h0; vv_n = 0; err_n = 0;
    for (int j = 0; j < 10; j++) begin
      if (busy) busy_n++;
      if (error) err_n++;
      if (value_valid) begin
        vv_n++;
        if (lat < 0) begin lat = j; got = value; end
      end
      if (noise && j < 5) begin
        clear       = 1'($urandom_range(0, 1));
        enter       = 1'($urandom_range(0, 1));
        backspace   = 1'($urandom_range(0, 1));
        digit_valid = 1'($urandom_range(0, 1));
        digit       = 4'($urandom_range(0, 15));
      end else begin
        idle_inputs();
      end
      tick();
    end
    idle_inputs();
    exp_value = model_number();
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
    digs.delete(); exp_err = 1'b0; exp_value = 16'h0;
    checks++; if (bcd !== 16'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({busy, value_valid, error} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, value_valid, error}); end
    checks++; if (value !== 16'h0) begin failures++; $display("FAIL reset_value got=%h exp=0000", value); end
  endtask

  task automatic test_basic_convert();
    int bn, lat, vn, en;
    logic [15:0] got;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd2);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd4);
    step(1'b0, 1'b0, 1'b1, 4'd7);
    checks++; if (bcd !== 16'h2047) begin failures++; $display("FAIL basic_bcd got=%h exp=2047", bcd); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL basic_count got=%0d exp=4", count); end
    run_enter(1'b0, 1'b0, 4'd0, 1'b0, bn, lat, got, vn, en);
    checks++; if (got !== 16'd2047) begin failures++; $display("FAIL basic_value got=%0d exp=2047", got); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    checks++; if (bn !== 5) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=5", bn); end
    checks++; if (vn !== 1) begin failures++; $display("FAIL basic_valid_pulses got=%0d exp=1", vn); end
    checks++; if (bcd !== 16'h2047 || count !== 3'd4) begin failures++; $display("FAIL basic_retain got=%h/%0d exp=2047/4", bcd, count); end
    checks++; if (value !== 16'h07FF) begin failures++; $display("FAIL basic_value_hold got=%h exp=07ff", value); end
  endtask

  task automatic test_backspace();
    int bn, lat, vn, en;
    logic [15:0] got;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd1);
    step(1'b0, 1'b0, 1'b1, 4'd2);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    checks++; if (bcd !== 16'h0012 || count !== 3'd2) begin failures++; $display("FAIL bs_bcd got=%h/%0d exp=0012/2", bcd, count); end
    run_enter(1'b0, 1'b0, 4'd0, 1'b0, bn, lat, got, vn, en);
    checks++; if (got !== 16'd12 || vn !== 1) begin failures++; $display("FAIL bs_value got=%0d/%0d exp=12/1", got, vn); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0);
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL bs_no_error got=%b exp=0", error); end
    end
    checks++; if (count !== 3'd0 || bcd !== 16'h0) begin failures++; $display("FAIL bs_empty got=%h/%0d exp=0000/0", bcd, count); end
  endtask

  task automatic test_error();
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b0, 1'b1, 4'hA);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_bad_digit got=%b exp=1", error); end
    checks++; if (bcd !== 16'h0005 || count !== 3'd1) begin failures++; $display("FAIL err_bcd_kept got=%h/%0d exp=0005/1", bcd, count); end
    tick();
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", error); end
    step(1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b1, 4'(k));
    step(1'b0, 1'b0, 1'b1, 4'd9);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL err_full got=%b exp=1", error); end
    checks++; if (bcd !== 16'h1234 || count !== 3'd4) begin failures++; $display("FAIL err_full_bcd got=%h/%0d exp=1234/4", bcd, count); end
  endtask

  task automatic test_extremes();
    int bn, lat, vn, en;
    logic [15:0] got;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 4'd9);
    run_enter(1'b0, 1'b0, 4'd0, 1'b0, bn, lat, got, vn, en);
    checks++; if (got !== 16'h270F || lat !== 5) begin failures++; $display("FAIL max_value got=%h@%0d exp=270f@5", got, lat); end
    step(1'b1, 1'b0, 1'b0, 4'd0);
    run_enter(1'b0, 1'b0, 4'd0, 1'b0, bn, lat, got, vn, en);
    checks++; if (got !== 16'h0 || vn !== 1 || lat !== 5) begin failures++; $display("FAIL empty_value got=%h/%0d@%0d exp=0000/1@5", got, vn, lat); end
  endtask

  task automatic test_priority_and_busy();
    int bn, lat, vn, en;
    logic [15:0] got;
    step(1'b0, 1'b0, 1'b1, 4'd3);
    step(1'b1, 1'b0, 1'b1, 4'd7);
    checks++; if (bcd !== 16'h0 || count !== 3'd0) begin failures++; $display("FAIL clear_wins got=%h/%0d exp=0000/0", bcd, count); end
    step(1'b0, 1'b0, 1'b1, 4'd3);
    step(1'b0, 1'b0, 1'b1, 4'd1);
    // enter outranks the simultaneous digit; strobes during busy are dropped
    run_enter(1'b0, 1'b1, 4'd8, 1'b1, bn, lat, got, vn, en);
    checks++; if (got !== 16'd31 || lat !== 5 || vn !== 1) begin failures++; $display("FAIL busy_ignore got=%0d@%0d/%0d exp=31@5/1", got, lat, vn); end
    checks++; if (bcd !== 16'h0031 || count !== 3'd2) begin failures++; $display("FAIL busy_bcd got=%h/%0d exp=0031/2", bcd, count); end
    checks++; if (en !== 0) begin failures++; $display("FAIL busy_error got=%0d exp=0", en); end
  endtask

  task automatic test_reset_mid_conv();
    int vn;
    step(1'b0, 1'b0, 1'b1, 4'd6);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    digs.delete(); exp_value = 16'h0; exp_err = 1'b0;
    checks++; if (busy !== 1'b0 || value !== 16'h0) begin failures++; $display("FAIL midrst_state got=%b/%h exp=0/0000", busy, value); end
    checks++; if (bcd !== 16'h0 || count !== 3'd0) begin failures++; $display("FAIL midrst_bcd got=%h/%0d exp=0000/0", bcd, count); end
    vn = 0;
    for (int k = 0; k < 8; k++) begin
      if (value_valid) vn++;
      tick();
    end
    checks++; if (vn !== 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", vn); end
  endtask

  task automatic test_random();
    int bn, lat, vn, en;
    logic [15:0] got;
    logic c, e, b, dv;
    logic [3:0] d;
    for (int it = 0; it < 300; it++) begin
      c  = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 9) == 0);
      b  = ($urandom_range(0, 4) == 0);
      dv = ($urandom_range(0, 4) < 3);
      d  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if (e && !c) begin
        run_enter(b, dv, d, 1'($urandom_range(0, 1)), bn, lat, got, vn, en);
        checks++; if (got !== exp_value || lat !== 5 || vn !== 1) begin failures++; $display("FAIL rand_conv it=%0d got=%0d@%0d/%0d exp=%0d@5/1", it, got, lat, vn, exp_value); end
      end else begin
        step(c, b, dv, d);
        checks++;
        if (bcd !== model_bcd() || count !== 3'(digs.size()) || error !== exp_err || value !== exp_value || busy !== 1'b0) begin
          failures++;
          $display("FAIL rand_step it=%0d got=%h/%0d/%b/%h exp=%h/%0d/%b/%h", it, bcd, count, error, value,
                   model_bcd(), digs.size(), exp_err, exp_value);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    exp_err = 1'b0;
    exp_value = 16'h0;
    test_reset();
    test_basic_convert();
    test_backspace();
    test_error();
    test_extremes();
    test_priority_and_busy();
    test_reset_mid_conv();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
